// File: rtl/enc4x2_seq.sv
// Registered 4-to-2 request encoder: queues single-cycle request pulses and
// issues them one at a time as a 2-bit code under a valid/ready handshake.
module enc4x2_seq #(
  parameter bit RR = 1'b0  // 0: fixed priority (lowest index), 1: round-robin
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] code,
  output logic       out_valid,
  output logic [3:0] pending,
  output logic       dropped
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [3:0] pending_q, pending_d;
  logic       dropped_q, dropped_d;
  logic [1:0] last_q, last_d;

  logic [3:0] cand;
  logic [1:0] sel;
  logic       load;

  // Requests are eligible in the cycle they arrive, so the search covers both.
  assign cand = pending_q | req;

  always_comb begin
    logic [1:0] idx;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    sel = 2'd0;
    idx = 2'd0;
    if (RR) begin
      // Walk from last+4 (== last) down to last+1; the final hit is the first in search order.
      for (int k = 4; k >= 1; k--) begin
        idx = last_q + 2'(k);
        if (cand[idx]) sel = idx;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (cand[i]) sel = 2'(i);
      end
    end
  end

  // A new code is taken whenever the output register is free or being emptied.
  assign load = (cand != 4'b0000) && ((state_q == IDLE) || out_ready);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    pending_d = cand;
    dropped_d = dropped_q | (|(req & pending_q));

    case (state_q)
      IDLE: begin
        if (load) state_d = SEND;
      end
      SEND: begin
        if (out_ready && !load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      code_d    = sel;
      last_d    = sel;
      pending_d = cand & ~(4'b0001 << sel);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= 2'd0;
      pending_q <= 4'b0000;
      dropped_q <= 1'b0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      last_q    <= last_d;
    end
  end

  assign code      = code_q;
  assign out_valid = (state_q == SEND);
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_enc4x2_seq.sv
// Directed table-driven bench for enc4x2_seq: one fixed-priority and one
// round-robin instance, plus hand-written reset sequences.
module tb_enc4x2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req0, req1;
  logic       rdy0, rdy1;
  logic [1:0] code0, code1;
  logic       valid0, valid1;
  logic [3:0] pend0, pend1;
  logic       drop0, drop1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enc4x2_seq #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req0), .out_ready(rdy0),
    .code(code0), .out_valid(valid0), .pending(pend0), .dropped(drop0)
  );

  enc4x2_seq #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req1), .out_ready(rdy1),
    .code(code1), .out_valid(valid1), .pending(pend1), .dropped(drop1)
  );

  typedef struct packed {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pending;
    logic       dropped;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {code,valid,pending,dropped}=%b, need %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] c);
    logic [3:0] d;
    d = 4'b0000;
    d[c] = 1'b1;
    return d;
  endfunction

  // Drive one edge on the selected instance and compare its outputs after it.
  task automatic run_row(input string name, input vec_t v, input bit rr);
    if (rr) begin req1 = v.req; rdy1 = v.rdy; end
    else    begin req0 = v.req; rdy0 = v.rdy; end
    @(posedge clk); #1;
    if (rr) check(name, {code1, valid1, pend1, drop1}, {v.code, v.valid, v.pending, v.dropped});
    else    check(name, {code0, valid0, pend0, drop0}, {v.code, v.valid, v.pending, v.dropped});
    req0 = 4'b0000; req1 = 4'b0000;
  endtask

  vec_t fp_tab [24];
  vec_t rr_tab [8];

  initial begin
    //            req      rdy   code   v     pending  drop
    // single request
    fp_tab[0]  = {4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
    fp_tab[1]  = {4'b0100, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0};
    fp_tab[2]  = {4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
    // fixed-priority burst
    fp_tab[3]  = {4'b1111, 1'b1, 2'd0, 1'b1, 4'b1110, 1'b0};
    fp_tab[4]  = {4'b0000, 1'b1, 2'd1, 1'b1, 4'b1100, 1'b0};
    fp_tab[5]  = {4'b0000, 1'b1, 2'd2, 1'b1, 4'b1000, 1'b0};
    fp_tab[6]  = {4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
    fp_tab[7]  = {4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};
    // backpressure: out_ready ignored while idle, then 5 stalled cycles
    fp_tab[8]  = {4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0};
    fp_tab[9]  = {4'b1000, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b0};
    fp_tab[10] = {4'b0000, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b0};
    fp_tab[11] = {4'b0000, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b0};
    fp_tab[12] = {4'b0000, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b0};
    fp_tab[13] = {4'b0000, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b0};
    fp_tab[14] = {4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
    fp_tab[15] = {4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};
    // re-request of the in-flight index re-queues without a drop
    fp_tab[16] = {4'b0001, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
    fp_tab[17] = {4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0};
    fp_tab[18] = {4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0};
    fp_tab[19] = {4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
    // merge into a pending bit sets the sticky drop flag
    fp_tab[20] = {4'b0101, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b0};
    fp_tab[21] = {4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1};
    fp_tab[22] = {4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b1};
    fp_tab[23] = {4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b1};

    // round-robin from reset (last=3)
    rr_tab[0]  = {4'b0010, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0};
    rr_tab[1]  = {4'b0011, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b0};
    rr_tab[2]  = {4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0};
    rr_tab[3]  = {4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0};
    rr_tab[4]  = {4'b1011, 1'b1, 2'd3, 1'b1, 4'b0011, 1'b0};
    rr_tab[5]  = {4'b0000, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b0};
    rr_tab[6]  = {4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0};
    rr_tab[7]  = {4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0};

    // reset held two edges with requests present
    rst_n = 1'b0; req0 = 4'b1111; req1 = 4'b1111; rdy0 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_fp[%0d]", i), {code0, valid0, pend0, drop0}, 8'h00);
      check($sformatf("reset_rr[%0d]", i), {code1, valid1, pend1, drop1}, 8'h00);
    end
    rst_n = 1'b1; req0 = 4'b0000; req1 = 4'b0000;

    for (int i = 0; i < 24; i++) begin
      run_row($sformatf("fp_row[%0d]", i), fp_tab[i], 1'b0);
      if (i == 1) check("decoder_D", {4'b0000, decode(code0)}, 8'b0000_0100);
    end

    for (int i = 0; i < 8; i++)
      run_row($sformatf("rr_row[%0d]", i), rr_tab[i], 1'b1);

    // mid-operation reset with pending=1010 and a code in flight
    run_row("pre_reset", {4'b1011, 1'b0, 2'd0, 1'b1, 4'b1010, 1'b1}, 1'b0);
    rst_n = 1'b0; req0 = 4'b1111; rdy0 = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", {code0, valid0, pend0, drop0}, 8'h00);
    rst_n = 1'b1; req0 = 4'b0000; rdy0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset[%0d]", i), {code0, valid0, pend0, drop0}, 8'h00);
    end

    // after reset the fixed-priority pick restarts from index 0
    run_row("fp_after_reset", {4'b1001, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b0}, 1'b0);
    run_row("fp_after_reset2", {4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
